// File: rtl/trisc_pkg.sv
// trisc_pkg: shared definitions for the T-RISC data RAM arbiter.
//   - arb_state_t : arbiter state encoding (IDLE, RD_WAIT)
//   - TRISC_AW/DW : default RAM address / data widths
//   - DRAMAX      : highest data RAM word address
package trisc_pkg;

  localparam int TRISC_AW = 12;
  localparam int TRISC_DW = 32;
  localparam int DRAMAX   = 4095;

  typedef enum logic {
    IDLE    = 1'b0,
    RD_WAIT = 1'b1
  } arb_state_t;

endpackage

// File: rtl/trisc_arb_starve.sv
// trisc_arb_starve: host starvation guard for trisc_dram_arb.
// Counts consecutive cycles in which a valid host request is refused and
// raises a registered hold once the count reaches STARVE_MAX.
// Ports:
//   clk          in   system clock
//   reset        in   asynchronous, active-low reset
//   i_wait       in   host request pending but refused this cycle (IDLE only)
//   i_grant      in   host request accepted this cycle
//   i_host_valid in   host request valid
//   o_hold       out  freeze request for the CPU (registered)
module trisc_arb_starve #(
  parameter int STARVE_MAX = 15
) (
  input  logic clk,
  input  logic reset,
  input  logic i_wait,
  input  logic i_grant,
  input  logic i_host_valid,
  output logic o_hold
);

  localparam int CW = (STARVE_MAX < 2) ? 1 : $clog2(STARVE_MAX + 1);
  localparam logic [CW-1:0] CMAX = CW'(STARVE_MAX);

  logic [CW-1:0] r_cnt;
  logic [CW-1:0] w_cnt_nxt;
  logic          r_hold;
  logic          w_hold_nxt;

  always_comb begin
    w_cnt_nxt  = r_cnt;
    w_hold_nxt = r_hold;
    // A withdrawn host request also releases the hold so the CPU can
    // never be left frozen with nobody waiting for the RAM.
    if (i_grant || !i_host_valid) begin
      w_cnt_nxt  = '0;
      w_hold_nxt = 1'b0;
    end else begin
      if (i_wait && (r_cnt != CMAX)) begin
        w_cnt_nxt = r_cnt + CW'(1);
      end
      // Hold is raised at the same edge the counter reaches the limit, so
      // it is visible in the cycle after the STARVE_MAX-th refusal.
      if (w_cnt_nxt == CMAX) begin
        w_hold_nxt = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_cnt  <= '0;
      r_hold <= 1'b0;
    end else begin
      r_cnt  <= w_cnt_nxt;
      r_hold <= w_hold_nxt;
    end
  end

  assign o_hold = r_hold;

endmodule

// File: rtl/trisc_dram_arb.sv
// trisc_dram_arb: shares the single-port T-RISC data RAM between the CPU
// load/store path (fixed priority, never stalls) and a host valid/ready port.
// Optional starvation guard compiled in with macro TRISC_ARB_STARVE_EN.
// Ports:
//   clk, reset                    clock; asynchronous active-low reset
//   cpu_req/we/addr/wdata   in    CPU RAM access
//   cpu_rdata               out   ram_q passthrough
//   host_valid/we/addr/wdata in   host request channel
//   host_ready              out   host request accepted (combinational)
//   host_rvalid/rdata       out   registered host read response (1-cycle pulse)
//   cpu_hold                out   CPU freeze request (registered, 0 without guard)
//   ram_addr/data/we        out   to RAM
//   ram_q                   in    RAM registered read data
module trisc_dram_arb
  import trisc_pkg::*;
#(
  parameter int AW         = TRISC_AW,
  parameter int DW         = TRISC_DW,
  parameter int STARVE_MAX = 15
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          cpu_req,
  input  logic          cpu_we,
  input  logic [AW-1:0] cpu_addr,
  input  logic [DW-1:0] cpu_wdata,
  output logic [DW-1:0] cpu_rdata,
  input  logic          host_valid,
  input  logic          host_we,
  input  logic [AW-1:0] host_addr,
  input  logic [DW-1:0] host_wdata,
  output logic          host_ready,
  output logic          host_rvalid,
  output logic [DW-1:0] host_rdata,
  output logic          cpu_hold,
  output logic [AW-1:0] ram_addr,
  output logic [DW-1:0] ram_data,
  output logic          ram_we,
  input  logic [DW-1:0] ram_q
);

  arb_state_t    r_state;
  arb_state_t    w_state_nxt;
  logic          w_host_ready;
  logic          w_hold;
  logic          r_rvalid;
  logic [DW-1:0] r_rdata;

`ifdef TRISC_ARB_STARVE_EN
  logic w_wait;

  assign w_wait = (r_state == IDLE) & host_valid & ~w_host_ready;

  trisc_arb_starve #(
    .STARVE_MAX (STARVE_MAX)
  ) u_starve (
    .clk          (clk),
    .reset        (reset),
    .i_wait       (w_wait),
    .i_grant      (w_host_ready),
    .i_host_valid (host_valid),
    .o_hold       (w_hold)
  );
`else
  logic w_unused_starve;

  assign w_unused_starve = (STARVE_MAX == 0);
  assign w_hold          = 1'b0;
`endif

  // Host is granted only in IDLE; the CPU wins any contention unless held.
  always_comb begin
    w_host_ready = 1'b0;
    if (r_state == IDLE) begin
      w_host_ready = host_valid & (~cpu_req | w_hold);
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      IDLE:    if (w_host_ready && !host_we) w_state_nxt = RD_WAIT;
      RD_WAIT: w_state_nxt = IDLE;
    endcase
  end

  // ram_q during RD_WAIT carries the host address issued in the grant
  // cycle, even if the CPU drives a new read address in this cycle.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state  <= IDLE;
      r_rvalid <= 1'b0;
      r_rdata  <= '0;
    end else begin
      r_state  <= w_state_nxt;
      r_rvalid <= (r_state == RD_WAIT);
      if (r_state == RD_WAIT) begin
        r_rdata <= ram_q;
      end
    end
  end

  assign ram_addr    = w_host_ready ? host_addr  : cpu_addr;
  assign ram_data    = w_host_ready ? host_wdata : cpu_wdata;
  assign ram_we      = w_host_ready ? host_we    : (cpu_req & cpu_we & ~w_hold);

  assign host_ready  = w_host_ready;
  assign host_rvalid = r_rvalid;
  assign host_rdata  = r_rdata;
  assign cpu_hold    = w_hold;
  assign cpu_rdata   = ram_q;

endmodule

// File: tb/tb_trisc_dram_arb.sv
module tb_trisc_dram_arb;

  localparam int AW = 12;
  localparam int DW = 32;

  logic          clk = 1'b0;
  logic          reset;
  logic          cpu_req, cpu_we;
  logic [AW-1:0] cpu_addr;
  logic [DW-1:0] cpu_wdata, cpu_rdata;
  logic          host_valid, host_we;
  logic [AW-1:0] host_addr;
  logic [DW-1:0] host_wdata;
  logic          host_ready, host_rvalid;
  logic [DW-1:0] host_rdata;
  logic          cpu_hold;
  logic [AW-1:0] ram_addr;
  logic [DW-1:0] ram_data;
  logic          ram_we;
  logic [DW-1:0] ram_q;

  int n_checks = 0;
  int n_fail   = 0;

  logic [DW-1:0] mem [0:4095];

  trisc_dram_arb #(
    .AW (AW), .DW (DW), .STARVE_MAX (3)
  ) dut (
    .clk (clk), .reset (reset),
    .cpu_req (cpu_req), .cpu_we (cpu_we), .cpu_addr (cpu_addr),
    .cpu_wdata (cpu_wdata), .cpu_rdata (cpu_rdata),
    .host_valid (host_valid), .host_we (host_we), .host_addr (host_addr),
    .host_wdata (host_wdata), .host_ready (host_ready),
    .host_rvalid (host_rvalid), .host_rdata (host_rdata),
    .cpu_hold (cpu_hold),
    .ram_addr (ram_addr), .ram_data (ram_data), .ram_we (ram_we),
    .ram_q (ram_q)
  );

  always #5 clk = ~clk;

  // Single-port RAM with registered read data.
  always @(posedge clk) begin
    if (ram_we) mem[ram_addr] <= ram_data;
    ram_q <= mem[ram_addr];
  end

  task automatic chk(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    cpu_req = 1'b0; cpu_we = 1'b0; cpu_addr = '0; cpu_wdata = '0;
    host_valid = 1'b0; host_we = 1'b0; host_addr = '0; host_wdata = '0;
  endtask

  task automatic host_write(input logic [AW-1:0] a, input logic [DW-1:0] d, input string tag);
    host_valid = 1'b1; host_we = 1'b1; host_addr = a; host_wdata = d;
    #1;
    chk({tag, "_ready"}, DW'(host_ready), 32'd1);
    chk({tag, "_ram_we"}, DW'(ram_we), 32'd1);
    tick();
    host_valid = 1'b0; host_we = 1'b0;
  endtask

  task automatic host_read(input logic [AW-1:0] a, input logic [DW-1:0] exp, input string tag);
    host_valid = 1'b1; host_we = 1'b0; host_addr = a;
    #1;
    chk({tag, "_ready"}, DW'(host_ready), 32'd1);
    tick();
    host_valid = 1'b0;
    tick();
    chk({tag, "_rvalid"}, DW'(host_rvalid), 32'd1);
    chk({tag, "_rdata"}, host_rdata, exp);
  endtask

  initial begin
    idle_inputs();
    reset = 1'b0;
    tick(); tick();
    chk("rst_rvalid", DW'(host_rvalid), 32'd0);
    chk("rst_rdata", host_rdata, 32'd0);
    chk("rst_hold", DW'(cpu_hold), 32'd0);
    chk("rst_ready", DW'(host_ready), 32'd0);
    reset = 1'b1;
    tick();

    // Host write with CPU idle: granted and written in the same cycle.
    host_valid = 1'b1; host_we = 1'b1; host_addr = 12'h010; host_wdata = 32'hDEADBEEF;
    #1;
    chk("wr_ready", DW'(host_ready), 32'd1);
    chk("wr_ram_we", DW'(ram_we), 32'd1);
    chk("wr_ram_addr", DW'(ram_addr), 32'h010);
    chk("wr_ram_data", ram_data, 32'hDEADBEEF);
    tick();
    host_valid = 1'b0; host_we = 1'b0;

    // Host read, with a second request and a CPU read during RD_WAIT.
    host_valid = 1'b1; host_addr = 12'h010;
    #1;
    chk("rd_ready", DW'(host_ready), 32'd1);
    chk("rd_ram_we", DW'(ram_we), 32'd0);
    chk("rd_ram_addr", DW'(ram_addr), 32'h010);
    tick();
    cpu_req = 1'b1; cpu_addr = 12'h020;
    #1;
    chk("rdw_ready", DW'(host_ready), 32'd0);
    chk("rdw_rvalid", DW'(host_rvalid), 32'd0);
    chk("rdw_cpu_addr", DW'(ram_addr), 32'h020);
    host_valid = 1'b0; cpu_req = 1'b0;
    tick();
    chk("rd_rvalid", DW'(host_rvalid), 32'd1);
    chk("rd_rdata", host_rdata, 32'hDEADBEEF);
    tick();
    chk("rd_rvalid_pulse", DW'(host_rvalid), 32'd0);
    chk("rd_rdata_hold", host_rdata, 32'hDEADBEEF);

    // CPU read: cpu_rdata is ram_q with no extra latency.
    cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 12'h010;
    tick();
    cpu_req = 1'b0;
    chk("cpu_rdata", cpu_rdata, 32'hDEADBEEF);

    // Contention: CPU write wins, host granted once cpu_req drops.
    cpu_req = 1'b1; cpu_we = 1'b1; cpu_addr = 12'h030; cpu_wdata = 32'h11111111;
    host_valid = 1'b1; host_we = 1'b1; host_addr = 12'h040; host_wdata = 32'h22222222;
    #1;
    chk("con_ready", DW'(host_ready), 32'd0);
    chk("con_ram_addr", DW'(ram_addr), 32'h030);
    chk("con_ram_we", DW'(ram_we), 32'd1);
    chk("con_ram_data", ram_data, 32'h11111111);
    tick();
    chk("con_ready2", DW'(host_ready), 32'd0);
    chk("con_hold", DW'(cpu_hold), 32'd0);
    tick();
    cpu_req = 1'b0; cpu_we = 1'b0;
    #1;
    chk("con_grant", DW'(host_ready), 32'd1);
    chk("con_grant_addr", DW'(ram_addr), 32'h040);
    tick();
    host_valid = 1'b0; host_we = 1'b0;
    host_read(12'h030, 32'h11111111, "con_rb_cpu");
    host_read(12'h040, 32'h22222222, "con_rb_host");

`ifdef TRISC_ARB_STARVE_EN
    // Guard on, limit 3: hold after three refusals, CPU write suppressed.
    cpu_req = 1'b1; cpu_we = 1'b1; cpu_addr = 12'h050; cpu_wdata = 32'h55555555;
    host_valid = 1'b1; host_we = 1'b0; host_addr = 12'h010;
    for (int i = 0; i < 3; i++) begin
      #1;
      chk("stv_denied", DW'(host_ready), 32'd0);
      chk("stv_nohold", DW'(cpu_hold), 32'd0);
      tick();
    end
    #1;
    chk("stv_hold", DW'(cpu_hold), 32'd1);
    chk("stv_grant", DW'(host_ready), 32'd1);
    chk("stv_ram_addr", DW'(ram_addr), 32'h010);
    chk("stv_cpu_we_blocked", DW'(ram_we), 32'd0);
    tick();
    host_valid = 1'b0; cpu_req = 1'b0; cpu_we = 1'b0;
    #1;
    chk("stv_hold_clr", DW'(cpu_hold), 32'd0);
    chk("stv_rdwait_ready", DW'(host_ready), 32'd0);
    tick();
    chk("stv_rvalid", DW'(host_rvalid), 32'd1);
    chk("stv_rdata", host_rdata, 32'hDEADBEEF);
    tick();
`else
    // Guard absent: host starves while the CPU keeps the RAM.
    cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 12'h050;
    host_valid = 1'b1; host_we = 1'b0; host_addr = 12'h010;
    for (int i = 0; i < 8; i++) begin
      #1;
      chk("stv_denied", DW'(host_ready), 32'd0);
      chk("stv_nohold", DW'(cpu_hold), 32'd0);
      tick();
    end
    host_valid = 1'b0; cpu_req = 1'b0;
    tick();
`endif

    // Reset while a host read is outstanding: response dropped.
    host_valid = 1'b1; host_we = 1'b0; host_addr = 12'h010;
    #1;
    chk("rr_ready", DW'(host_ready), 32'd1);
    tick();
    host_valid = 1'b0;
    reset = 1'b0;
    #1;
    chk("rr_rvalid", DW'(host_rvalid), 32'd0);
    chk("rr_rdata", host_rdata, 32'd0);
    chk("rr_hold", DW'(cpu_hold), 32'd0);
    chk("rr_ready0", DW'(host_ready), 32'd0);
    tick();
    chk("rr_rvalid2", DW'(host_rvalid), 32'd0);
    reset = 1'b1;
    tick();
    chk("rr_rvalid3", DW'(host_rvalid), 32'd0);
    tick();
    chk("rr_rvalid4", DW'(host_rvalid), 32'd0);

    // Back-to-back host writes, one per cycle, then readback.
    host_valid = 1'b1; host_we = 1'b1;
    for (int i = 0; i < 8; i++) begin
      host_addr = AW'(i); host_wdata = 32'hC0DE0000 | DW'(i);
      #1;
      chk("b2b_ready", DW'(host_ready), 32'd1);
      tick();
    end
    host_valid = 1'b0; host_we = 1'b0;
    for (int i = 0; i < 8; i++) begin
      host_read(AW'(i), 32'hC0DE0000 | DW'(i), "b2b_rb");
    end
    host_write(12'hFFF, 32'h0BADF00D, "top_wr");
    host_read(12'hFFF, 32'h0BADF00D, "top_rb");

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/trisc_dram_arb.md
# trisc_dram_arb

Two-port arbiter that shares the T-RISC single-port 4096×32 data RAM between the CPU load/store path and an external host (loader/debug) port. The CPU has fixed priority because its pipeline cannot stall. The host uses a valid/ready request channel and receives read data through a registered response. An optional starvation guard raises `cpu_hold`, which the top level uses to freeze the CPU clock enable so a waiting host access can complete. Sits between the CPU core and the `data_ram` instance.

## Interface
- `AW`, default 12: RAM word-address width.
- `DW`, default 32: data width.
- `STARVE_MAX`, default 15: consecutive denied host cycles before `cpu_hold` asserts (only with the guard compiled in).
- `clk`  in  1  system clock, all state updates on the rising edge.
- `reset`  in  1  asynchronous, active-low reset.
- `cpu_req`  in  1  CPU accesses RAM this cycle.
- `cpu_we`  in  1  CPU write strobe, qualified by `cpu_req`.
- `cpu_addr`  in  AW  CPU word address.
- `cpu_wdata`  in  DW  CPU write data.
- `cpu_rdata`  out  DW  `ram_q` passthrough.
- `host_valid`  in  1  host request valid.
- `host_we`  in  1  host write (1) / read (0).
- `host_addr`  in  AW  host word address.
- `host_wdata`  in  DW  host write data.
- `host_ready`  out  1  host request accepted this cycle (combinational).
- `host_rvalid`  out  1  one-cycle pulse; `host_rdata` valid.
- `host_rdata`  out  DW  registered host read data.
- `cpu_hold`  out  1  request to freeze the CPU (registered).
- `ram_addr`  out  AW  to RAM.
- `ram_data`  out  DW  to RAM.
- `ram_we`  out  1  to RAM.
- `ram_q`  in  DW  RAM registered read data; valid one cycle after the address.

## Operation
- **Reset values:** state=IDLE, `host_rvalid`=0, `host_rdata`=0, `cpu_hold`=0, wait counter=0.
- **States:**
  - IDLE: normal arbitration.
  - RD_WAIT: a host read is outstanding.
- **Grant in IDLE:** `host_ready` = `host_valid` & (~`cpu_req` | `cpu_hold`).
- **RD_WAIT:** `host_ready`=0 for the whole state.
- **RAM mux:**
  - Host owns the RAM when `host_ready`=1. Then `ram_addr`=`host_addr`, `ram_data`=`host_wdata`, `ram_we`=`host_we`.
  - Otherwise `ram_addr`=`cpu_addr`, `ram_data`=`cpu_wdata`, `ram_we`=`cpu_req`&`cpu_we`&~`cpu_hold`.
- **Host write:** completes in the grant cycle; state stays IDLE.
- **Host read:**
  - Grant cycle N: go to RD_WAIT.
  - End of N+1: capture `ram_q` into `host_rdata`, pulse `host_rvalid`, return to IDLE.
- **CPU during RD_WAIT:** a CPU read in cycle N+1 is allowed. The host capture uses the N-address data, which is what `ram_q` holds during N+1.
- **Simultaneous requests:** CPU wins unless `cpu_hold`=1.
- **Reset mid-read:** the outstanding read is dropped and no `host_rvalid` is produced.

## Timing
- Host write latency: 0 (accepted = written at the closing edge).
- Host read latency: `host_rvalid` goes high 2 cycles after the grant cycle, for exactly 1 cycle.
- Maximum host throughput: 1 write/cycle; 1 read per 2 cycles.
- `cpu_rdata` adds no latency; it is combinational from `ram_q`.
- `cpu_hold` deasserts at the edge that ends the host grant cycle.

## Configuration
- Macro `TRISC_ARB_STARVE_EN`.
- **Defined:**
  - The wait counter increments each cycle that IDLE & `host_valid` & ~`host_ready`, saturating at `STARVE_MAX`.
  - The counter clears on any grant or when `host_valid`=0.
  - `cpu_hold` sets when the counter reaches `STARVE_MAX` and clears after the host grant.
  - While held, CPU writes are suppressed and `cpu_rdata` is don't-care.
- **Undefined:**
  - No counter is built; `cpu_hold` is tied to 0.
  - The host can starve indefinitely.

## Structure
- Shared package `trisc_pkg` holds:
  - the state encoding (IDLE, RD_WAIT);
  - the default `AW`/`DW` constants;
  - `DRAMAX`=4095.
- Natural sub-module: `trisc_arb_starve` (the saturating wait counter plus `cpu_hold` register). It is instantiated only under the macro.

## Test plan
- Host write of 0xDEADBEEF to address 0x010 with `cpu_req`=0 -> `host_ready`=1 in the same cycle, `ram_we`=1, `ram_addr`=0x010.
- Host read of 0x010 while idle -> `host_ready` pulse, `host_rvalid`=1 two cycles later with `host_rdata`=0xDEADBEEF; `host_ready`=0 in between.
- `cpu_req`=1 with `host_valid`=1 -> CPU address reaches the RAM and `host_ready`=0; host granted in the first cycle with `cpu_req`=0.
- Macro on, `STARVE_MAX`=3, `cpu_req` held at 1 with the host waiting -> `cpu_hold`=1 after 3 denied cycles, host granted next, `cpu_hold`=0 after the grant, CPU writes blocked while held.
- Host read granted, `reset` asserted in RD_WAIT -> no `host_rvalid`; all outputs at reset values.
- Back-to-back host writes to 0x000..0x007 with `cpu_req`=0 -> 8 consecutive grants; readback returns the same data.
